// File: rtl/updn_seq_monitor_pkg.sv
// Shared types and constants for the up/down sequence monitor: FSM states,
// fault codes and the default count width.
package updn_seq_monitor_pkg;

    localparam int UPDN_WIDTH = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACQ   = 3'd1,
        ST_UP    = 3'd2,
        ST_DOWN  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_STUCK = 2'b01;
    localparam logic [1:0] ERR_JUMP  = 2'b10;
    localparam logic [1:0] ERR_REV   = 2'b11;

endpackage

// File: rtl/updn_step_classify.sv
// Combinational comparison of the previous sample p against the new sample s.
// Step flags are one-hot; wrap-around (15->0, 0->15) is a jump, not a step.
module updn_step_classify #(
    parameter int WIDTH   = 4,
    parameter int MAX_VAL = 2**WIDTH-1
) (
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] s,
    output logic             STEP_UP,
    output logic             STEP_DN,
    output logic             SAME,
    output logic             JUMP,
    output logic             AT_TOP,
    output logic             AT_BOT
);

    localparam logic [WIDTH-1:0] TOP_VAL = MAX_VAL[WIDTH-1:0];

    // One extra bit so that p+1 at the top cannot alias to 0.
    logic [WIDTH:0] p_ext;
    logic [WIDTH:0] s_ext;

    assign p_ext   = {1'b0, p};
    assign s_ext   = {1'b0, s};
    assign STEP_UP = (s_ext == p_ext + 1'b1);
    assign STEP_DN = (p_ext == s_ext + 1'b1);
    assign SAME    = (p == s);
    assign JUMP    = ~(STEP_UP | STEP_DN | SAME);
    assign AT_TOP  = (p == TOP_VAL);
    assign AT_BOT  = (p == '0);

endmodule

// File: rtl/updn_seq_monitor.sv
// Checker for an up/down counter stream: tracks direction, flags turnarounds,
// measures the bottom-to-bottom period and latches a sticky fault code.
module updn_seq_monitor
    import updn_seq_monitor_pkg::*;
#(
    parameter int WIDTH   = UPDN_WIDTH,
    parameter int MAX_VAL = 2**WIDTH-1,
    parameter int PW      = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [WIDTH-1:0] CNT_IN,
    output logic             DIR,
    output logic             TURN,
    output logic [PW-1:0]    PERIOD,
    output logic             PERIOD_VLD,
    output logic             LOCKED,
    output logic             ERR,
    output logic [1:0]       ERR_CODE,
    output state_t           fsm_state
);

    state_t           state, state_nx;
    logic [WIDTH-1:0] p_q, p_nx;
    logic [PW-1:0]    cnt_q, cnt_nx, period_nx;
    logic             dir_nx, turn_nx, vld_nx, locked_nx, err_nx;
    logic [1:0]       code_nx, fcode;
    logic             fault, ref_step;
    logic             step_up, step_dn, same, jump, at_top, at_bot;

    updn_step_classify #(.WIDTH(WIDTH), .MAX_VAL(MAX_VAL)) u_classify (
        .p       (p_q),
        .s       (CNT_IN),
        .STEP_UP (step_up),
        .STEP_DN (step_dn),
        .SAME    (same),
        .JUMP    (jump),
        .AT_TOP  (at_top),
        .AT_BOT  (at_bot)
    );

    assign fsm_state = state;

    always_comb begin
        state_nx  = state;
        p_nx      = p_q;
        cnt_nx    = cnt_q;
        period_nx = PERIOD;
        dir_nx    = DIR;
        turn_nx   = 1'b0;
        vld_nx    = 1'b0;
        locked_nx = LOCKED;
        err_nx    = ERR;
        code_nx   = ERR_CODE;
        fault     = 1'b0;
        fcode     = ERR_NONE;
        ref_step  = 1'b0;
        if (EN) begin
            case (state)
                ST_IDLE: begin
                    p_nx     = CNT_IN;
                    state_nx = ST_ACQ;
                end
                ST_ACQ, ST_UP, ST_DOWN: begin
                    // Stuck and jump are checked first so a fault always beats a turnaround.
                    if (same) begin
                        fault = 1'b1;
                        fcode = ERR_STUCK;
                    end else if (jump) begin
                        fault = 1'b1;
                        fcode = ERR_JUMP;
                    end else if (state == ST_ACQ) begin
                        state_nx = step_up ? ST_UP : ST_DOWN;
                        dir_nx   = step_up;
                        ref_step = step_up && at_bot;
                    end else if (state == ST_UP) begin
                        if (step_dn) begin
                            if (at_top) begin
                                state_nx = ST_DOWN;
                                dir_nx   = 1'b0;
                                turn_nx  = 1'b1;
                            end else begin
                                fault = 1'b1;
                                fcode = ERR_REV;
                            end
                        end
                    end else begin
                        if (step_up) begin
                            if (at_bot) begin
                                state_nx = ST_UP;
                                dir_nx   = 1'b1;
                                turn_nx  = 1'b1;
                                ref_step = 1'b1;
                            end else begin
                                fault = 1'b1;
                                fcode = ERR_REV;
                            end
                        end
                    end

                    if (fault) begin
                        state_nx = ST_FAULT;
                        err_nx   = 1'b1;
                        code_nx  = fcode;
                    end else begin
                        p_nx = CNT_IN;
                        // cnt_q == 0 means no reference step has been seen since reset.
                        if (ref_step) begin
                            cnt_nx = PW'(1);
                            if (cnt_q != '0) begin
                                period_nx = cnt_q;
                                vld_nx    = 1'b1;
                                locked_nx = 1'b1;
                            end
                        end else if (cnt_q != '0 && cnt_q != '1) begin
                            cnt_nx = cnt_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_IDLE;
            p_q        <= '0;
            cnt_q      <= '0;
            PERIOD     <= '0;
            DIR        <= 1'b0;
            TURN       <= 1'b0;
            PERIOD_VLD <= 1'b0;
            LOCKED     <= 1'b0;
            ERR        <= 1'b0;
            ERR_CODE   <= ERR_NONE;
        end else begin
            state      <= state_nx;
            p_q        <= p_nx;
            cnt_q      <= cnt_nx;
            PERIOD     <= period_nx;
            DIR        <= dir_nx;
            TURN       <= turn_nx;
            PERIOD_VLD <= vld_nx;
            LOCKED     <= locked_nx;
            ERR        <= err_nx;
            ERR_CODE   <= code_nx;
        end
    end

endmodule

// File: tb/tb_updn_seq_monitor.sv
// Bench for updn_seq_monitor: directed scenarios plus a random walk, checked
// against a sample-history reference model; a PW=4 copy exercises saturation.
module tb_updn_seq_monitor;
    import updn_seq_monitor_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic [3:0] cnt_in = '0;

    logic       dir8, turn8, vld8, locked8, err8;
    logic [7:0] period8;
    logic [1:0] code8;
    state_t     state8;
    logic       dir4, turn4, vld4, locked4, err4;
    logic [3:0] period4;
    logic [1:0] code4;
    state_t     state4;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: accepted samples since reset plus derived flags.
    int  hist[$];
    bit  m_fault;
    int  m_code, m_dir, m_turn, m_vld, m_locked, m_ref, m_per8, m_per4;
    logic [7:0] exp_q[$];

    updn_seq_monitor #(.WIDTH(4), .PW(8)) dut8 (
        .CLK(clk), .RST(rst), .EN(en), .CNT_IN(cnt_in),
        .DIR(dir8), .TURN(turn8), .PERIOD(period8), .PERIOD_VLD(vld8),
        .LOCKED(locked8), .ERR(err8), .ERR_CODE(code8), .fsm_state(state8)
    );

    updn_seq_monitor #(.WIDTH(4), .PW(4)) dut4 (
        .CLK(clk), .RST(rst), .EN(en), .CNT_IN(cnt_in),
        .DIR(dir4), .TURN(turn4), .PERIOD(period4), .PERIOD_VLD(vld4),
        .LOCKED(locked4), .ERR(err4), .ERR_CODE(code4), .fsm_state(state4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int expected);
        n_checks++;
        if (obs == expected) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expected, $time);
    endtask

    task automatic model_reset();
        hist.delete();
        exp_q.delete();
        m_fault = 0; m_code = 0; m_dir = 0; m_turn = 0; m_vld = 0;
        m_locked = 0; m_ref = -1; m_per8 = 0; m_per4 = 0;
    endtask

    task automatic model_sample(input int s);
        int p, d, pd, n, span;
        m_turn = 0;
        m_vld  = 0;
        if (m_fault) return;
        if (hist.size() == 0) begin
            hist.push_back(s);
            return;
        end
        p  = hist[hist.size()-1];
        d  = s - p;
        pd = (hist.size() >= 2) ? p - hist[hist.size()-2] : 0;
        if (d == 0) begin m_fault = 1; m_code = 1; return; end
        if (d != 1 && d != -1) begin m_fault = 1; m_code = 2; return; end
        if (pd != 0 && d != pd) begin
            if ((pd == 1 && p == 15) || (pd == -1 && p == 0)) m_turn = 1;
            else begin m_fault = 1; m_code = 3; return; end
        end
        m_dir = (d == 1) ? 1 : 0;
        hist.push_back(s);
        n = hist.size() - 1;
        if (p == 0 && d == 1) begin
            if (m_ref >= 0) begin
                span     = n - m_ref;
                m_per8   = (span > 255) ? 255 : span;
                m_per4   = (span > 15) ? 15 : span;
                m_vld    = 1;
                m_locked = 1;
                exp_q.push_back(m_per8[7:0]);
            end
            m_ref = n;
        end
    endtask

    task automatic compare_all();
        chk("dir", dir8, m_dir);
        chk("turn", turn8, m_turn);
        chk("period", period8, m_per8);
        chk("period_vld", vld8, m_vld);
        chk("locked", locked8, m_locked);
        chk("err", err8, m_fault);
        chk("err_code", code8, m_code);
        chk("pw4_period", period4, m_per4);
        chk("pw4_vld", vld4, m_vld);
        chk("pw4_locked", locked4, m_locked);
        chk("pw4_err_code", code4, m_code);
        if (vld8) begin
            if (exp_q.size() == 0) chk("sb_spurious_vld", 1, 0);
            else chk("sb_period", period8, exp_q.pop_front());
        end
        chk("sb_pending", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        compare_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic step(input int s, input bit e);
        @(negedge clk);
        en     = e;
        cnt_in = 4'(e ? s : $urandom_range(0, 15));
        @(posedge clk);
        if (e) model_sample(s);
        else begin m_turn = 0; m_vld = 0; end
        #1;
        compare_all();
    endtask

    task automatic triangle(input bit gap);
        for (int v = 0; v <= 15; v++) begin step(v, 1); if (gap) step(0, 0); end
        for (int v = 14; v >= 0; v--) begin step(v, 1); if (gap) step(0, 0); end
        step(1, 1);
    endtask

    initial begin
        int pos, up;
        model_reset();

        // Full triangle, then same with idle gaps.
        do_reset();
        triangle(1'b0);
        chk("t1_period", period8, 30);
        chk("t1_vld", vld8, 1);
        chk("t1_locked", locked8, 1);
        chk("t1_err", err8, 0);
        chk("t6_pw4_period", period4, 15);
        chk("t6_pw4_locked", locked4, 1);
        do_reset();
        triangle(1'b1);
        chk("t2_period", period8, 30);

        // Wrap at the top.
        do_reset();
        for (int v = 10; v <= 15; v++) step(v, 1);
        step(0, 1);
        chk("t3_code", code8, 2);
        chk("t3_turn", turn8, 0);
        step(1, 1);
        step(2, 1);
        chk("t3_sticky", code8, 2);

        // Stuck, then mid-range reversal.
        do_reset();
        step(4, 1); step(5, 1); step(5, 1);
        chk("t4_stuck", code8, 1);
        do_reset();
        step(5, 1); step(6, 1); step(5, 1);
        chk("t4_rev", code8, 3);
        chk("t4_turn", turn8, 0);

        // Reset mid-run while going down.
        do_reset();
        for (int v = 0; v <= 15; v++) step(v, 1);
        for (int v = 14; v >= 9; v--) step(v, 1);
        do_reset();
        chk("t5_dir", dir8, 0);
        for (int v = 8; v >= 0; v--) step(v, 1);
        step(1, 1);
        chk("t5_no_vld", vld8, 0);
        for (int v = 2; v <= 15; v++) step(v, 1);
        for (int v = 14; v >= 0; v--) step(v, 1);
        step(1, 1);
        chk("t5_period", period8, 30);

        // Random walk with sporadic bad samples and idle cycles.
        for (int seg = 0; seg < 12; seg++) begin
            do_reset();
            pos = $urandom_range(0, 15);
            up  = $urandom_range(0, 1);
            for (int i = 0; i < 150; i++) begin
                if ($urandom_range(0, 3) == 0) step(0, 0);
                else if ($urandom_range(0, 59) == 0) step($urandom_range(0, 15), 1);
                else begin
                    step(pos, 1);
                    if (up != 0) begin if (pos == 15) begin up = 0; pos = 14; end else pos++; end
                    else begin if (pos == 0) begin up = 1; pos = 1; end else pos--; end
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
